// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and datapath select codes.
// The TRAP state exists only when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    StTrap     = 4'd10
`endif
  } state_e;

  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpAluImm = 7'h13;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpAluReg = 7'h33;
  localparam logic [6:0] OpBranch = 7'h63;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResMemData   = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmTypeI = 2'b00;
  localparam logic [1:0] ImmTypeS = 2'b01;
  localparam logic [1:0] ImmTypeB = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    unique case (opcode)
      OpStore:  return ImmTypeS;
      OpBranch: return ImmTypeB;
      default:  return ImmTypeI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory request and flags a timeout on the
// WAIT_LIMIT-th stalled cycle.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam logic [7:0] LastWait = 8'(WAIT_LIMIT - 1);

  logic [7:0] count_q, count_d;
  logic       stalled;

  assign stalled   = active_i & ~ready_i;
  // count_q holds the waits already seen, so this cycle is wait number count_q + 1
  assign timeout_o = stalled & (count_q == LastWait);

  always_comb begin
    count_d = '0;
    if (stalled && !clear_i && !timeout_o) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V style control FSM with memory wait timeout.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unrecognised opcodes and expose ILLEGAL.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] OPE_CODE,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       PC_EN,
  output logic       IR_WRITE,
  output logic       ADR_SRC,
  output logic       MEM_WRITE,
  output logic       REG_WRITE,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] ALU_OPE,
  output logic [1:0] RESULT_SRC,
  output logic [1:0] IMM_SRC,
  output logic       MEM_ERR,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  output logic       ILLEGAL,
`endif
  output logic [3:0] STATE
);

  state_e     state_q, state_d;
  logic       mem_req, ir_write, pc_write, branch, adr_src, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, alu_ope, result_src;
  logic       timeout, state_change;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (timeout) begin
          state_d = StFetch;
        end else if (MEM_READY) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (OPE_CODE)
          OpLoad, OpStore: state_d = StMemAdr;
          OpAluReg:        state_d = StExecR;
          OpAluImm:        state_d = StExecI;
          OpBranch:        state_d = StBeq;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:         state_d = StTrap;
`else
          default:         state_d = StFetch;
`endif
        endcase
      end
      StMemAdr:   state_d = (OPE_CODE == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (timeout) begin
          state_d = StFetch;
        end else if (MEM_READY) begin
          state_d = StMemWb;
        end
      end
      StMemWrite: begin
        if (timeout || MEM_READY) begin
          state_d = StFetch;
        end
      end
      StExecR, StExecI:       state_d = StAluWb;
      StMemWb, StAluWb, StBeq: state_d = StFetch;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      StTrap:                 state_d = StTrap;
`endif
      default:                state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBReg;
    alu_ope    = AluOpAdd;
    result_src = ResAluOut;
    case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = MEM_READY;
        pc_write   = MEM_READY;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResMemData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        alu_src_a = SrcAReg;
        alu_ope   = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        alu_ope   = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StBeq: begin
        alu_src_a = SrcAReg;
        alu_ope   = AluOpSub;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_change = (state_d != state_q);

  multicycle_control_fsm_mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_mem_wait_timer (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .active_i (mem_req),
    .ready_i  (MEM_READY),
    .clear_i  (state_change),
    .timeout_o(timeout)
  );

  // Write enables and the error pulse are masked while reset is held low
  assign MEM_REQ    = mem_req & RST_N;
  assign IR_WRITE   = ir_write & RST_N;
  assign MEM_WRITE  = mem_write & RST_N;
  assign REG_WRITE  = reg_write & RST_N;
  assign PC_EN      = (pc_write | (branch & ZERO)) & RST_N;
  assign MEM_ERR    = timeout & RST_N;
  assign ADR_SRC    = adr_src;
  assign ALU_SRC_A  = alu_src_a;
  assign ALU_SRC_B  = alu_src_b;
  assign ALU_OPE    = alu_ope;
  assign RESULT_SRC = result_src;
  assign IMM_SRC    = imm_src_of(OPE_CODE);
  assign STATE      = state_q;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign ILLEGAL    = (state_q == StTrap);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected controls are queued by the
// stimulus and compared by an independent negedge monitor.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [6:0] ope_code;
  logic       mem_req, pc_en, ir_write, adr_src, mem_write, reg_write, mem_err, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_ope, result_src, imm_src;
  logic [3:0] state;

  typedef struct {
    string       tag;
    logic [21:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [21:0] mon_act;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .WAIT_LIMIT(4)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .OPE_CODE  (ope_code),
    .ZERO      (zero),
    .MEM_READY (mem_ready),
    .MEM_REQ   (mem_req),
    .PC_EN     (pc_en),
    .IR_WRITE  (ir_write),
    .ADR_SRC   (adr_src),
    .MEM_WRITE (mem_write),
    .REG_WRITE (reg_write),
    .ALU_SRC_A (alu_src_a),
    .ALU_SRC_B (alu_src_b),
    .ALU_OPE   (alu_ope),
    .RESULT_SRC(result_src),
    .IMM_SRC   (imm_src),
    .MEM_ERR   (mem_err),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    .ILLEGAL   (illegal),
`endif
    .STATE     (state)
  );

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  // Control table for one cycle: {state, mem_req, ir_write, pc_en, adr_src, mem_write,
  // reg_write, mem_err, alu_a, alu_b, alu_ope, result_src, imm_src, illegal}
  function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic rdy, input logic zr,
                                          input logic rst, input logic [6:0] opc,
                                          input logic err);
    logic mreq, irw, pcw, pcen, adr, mw, rw, br, ill, e;
    logic [1:0] a, b, op, rs, imm;
    mreq = 0; irw = 0; pcw = 0; adr = 0; mw = 0; rw = 0; br = 0; ill = 0; e = err;
    a = 2'b00; b = 2'b00; op = 2'b00; rs = 2'b00;
    case (st)
      4'd0: begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      4'd1: begin a = 2'b01; b = 2'b01; end
      4'd2: begin a = 2'b10; b = 2'b01; end
      4'd3: begin mreq = 1; adr = 1; end
      4'd4: begin rs = 2'b01; rw = 1; end
      4'd5: begin mreq = 1; adr = 1; mw = 1; end
      4'd6: begin a = 2'b10; op = 2'b10; end
      4'd7: begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd8: rw = 1;
      4'd9: begin a = 2'b10; op = 2'b01; br = 1; end
      4'd10: ill = 1;
      default: ;
    endcase
    imm  = (opc == 7'h23) ? 2'b01 : (opc == 7'h63) ? 2'b10 : 2'b00;
    pcen = pcw | (br & zr);
    if (!rst) begin
      mreq = 0; irw = 0; mw = 0; rw = 0; pcen = 0; e = 0;
    end
    return {st, mreq, irw, pcen, adr, mw, rw, e, a, b, op, rs, imm, ill};
  endfunction

  task automatic step(input string tag, input logic rdy, input logic zr, input logic [6:0] opc,
                      input logic [3:0] st, input logic err);
    exp_t e;
    mem_ready = rdy;
    zero      = zr;
    ope_code  = opc;
    e.tag     = tag;
    e.vec     = exp_vec(st, rdy, zr, rst_n, opc, err);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_act = {state, mem_req, ir_write, pc_en, adr_src, mem_write, reg_write, mem_err,
                 alu_src_a, alu_src_b, alu_ope, result_src, imm_src, illegal};
      checks  = checks + 1;
      if (mon_act !== mon_e.vec) begin
        failures = failures + 1;
        $display("FAIL %s: got %b expected %b", mon_e.tag, mon_act, mon_e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; ope_code = 7'h03;
    repeat (2) @(posedge clk);
    #1;
    step("reset_held", 1, 0, 7'h03, StFetch, 0);
    rst_n = 1'b1;
    step("reset_release", 0, 0, 7'h03, StFetch, 0);

    // lw, no wait states: 5 cycles
    step("lw_fetch", 1, 0, 7'h03, StFetch, 0);
    step("lw_decode", 1, 0, 7'h03, StDecode, 0);
    step("lw_memadr", 1, 0, 7'h03, StMemAdr, 0);
    step("lw_memread", 1, 0, 7'h03, StMemRead, 0);
    step("lw_memwb", 1, 0, 7'h03, StMemWb, 0);

    // beq taken then not taken: 3 cycles each
    step("beq1_fetch", 1, 1, 7'h63, StFetch, 0);
    step("beq1_decode", 1, 1, 7'h63, StDecode, 0);
    step("beq1_taken", 1, 1, 7'h63, StBeq, 0);
    step("beq0_fetch", 1, 0, 7'h63, StFetch, 0);
    step("beq0_decode", 1, 0, 7'h63, StDecode, 0);
    step("beq0_nottaken", 1, 0, 7'h63, StBeq, 0);

    // sw with 3 wait states; ready arrives in the limit cycle
    step("sw_fetch", 1, 0, 7'h23, StFetch, 0);
    step("sw_decode", 1, 0, 7'h23, StDecode, 0);
    step("sw_memadr", 1, 0, 7'h23, StMemAdr, 0);
    for (int i = 0; i < 3; i++) step("sw_wait", 0, 0, 7'h23, StMemWrite, 0);
    step("sw_done", 1, 0, 7'h23, StMemWrite, 0);

    // R-type and I-type: 4 cycles each
    step("r_fetch", 1, 0, 7'h33, StFetch, 0);
    step("r_decode", 1, 0, 7'h33, StDecode, 0);
    step("r_exec", 1, 0, 7'h33, StExecR, 0);
    step("r_aluwb", 1, 0, 7'h33, StAluWb, 0);
    step("i_fetch", 1, 0, 7'h13, StFetch, 0);
    step("i_decode", 1, 0, 7'h13, StDecode, 0);
    step("i_exec", 1, 0, 7'h13, StExecI, 0);
    step("i_aluwb", 1, 0, 7'h13, StAluWb, 0);

    // fetch stuck: error on the 4th wait only, counter restarts afterwards
    for (int i = 0; i < 3; i++) step("fetch_wait", 0, 0, 7'h33, StFetch, 0);
    step("fetch_timeout", 0, 0, 7'h33, StFetch, 1);
    step("fetch_after_to", 0, 0, 7'h33, StFetch, 0);

    // lw read timeout aborts to fetch without write-back
    step("lwto_fetch", 1, 0, 7'h03, StFetch, 0);
    step("lwto_decode", 1, 0, 7'h03, StDecode, 0);
    step("lwto_memadr", 1, 0, 7'h03, StMemAdr, 0);
    for (int i = 0; i < 3; i++) step("lwto_wait", 0, 0, 7'h03, StMemRead, 0);
    step("lwto_timeout", 0, 0, 7'h03, StMemRead, 1);
    step("lwto_abort", 0, 0, 7'h03, StFetch, 0);

    // reset asserted in EXECR overrides the ALUWB transition
    step("rst_fetch", 1, 0, 7'h33, StFetch, 0);
    step("rst_decode", 1, 0, 7'h33, StDecode, 0);
    rst_n = 1'b0;
    step("rst_in_exec", 1, 0, 7'h33, StExecR, 0);
    rst_n = 1'b1;
    step("rst_to_fetch", 0, 0, 7'h33, StFetch, 0);

    // unrecognised opcode
    step("ill_fetch", 1, 0, 7'h7F, StFetch, 0);
    step("ill_decode", 1, 0, 7'h7F, StDecode, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) step("ill_trap", 1, 1, 7'h7F, StTrap, 0);
    rst_n = 1'b0;
    step("ill_trap_reset", 1, 0, 7'h7F, StTrap, 0);
    rst_n = 1'b1;
    step("ill_after_reset", 0, 0, 7'h7F, StFetch, 0);
`else
    step("ill_back_fetch", 0, 0, 7'h7F, StFetch, 0);
`endif

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: MULTICYCLE_CONTROL_FSM

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum consecutive MEM_READY=0 cycles tolerated in a memory state, range 1..255.
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port OPE_CODE, input, 7: instruction opcode field from the instruction register.
REQ-005 SHALL have port ZERO, input, 1: ALU zero flag.
REQ-006 SHALL have port MEM_READY, input, 1: memory completes the current access this cycle.
REQ-007 SHALL have port MEM_REQ, output, 1: memory access request.
REQ-008 SHALL have outputs PC_EN, IR_WRITE, ADR_SRC, MEM_WRITE and REG_WRITE, each 1 bit; SHALL have outputs ALU_SRC_A, ALU_SRC_B, ALU_OPE, RESULT_SRC and IMM_SRC, each 2 bits; all are datapath controls.
REQ-009 SHALL have outputs MEM_ERR, 1 bit (memory timeout pulse), and STATE, 4 bits (current state, for debug).

Function
REQ-010 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB and BEQ.
REQ-011 SHALL transition FETCH->DECODE only when MEM_READY=1; otherwise it SHALL remain in FETCH.
REQ-012 SHALL decode in DECODE: 0x03 or 0x23 -> MEMADR; 0x33 -> EXECR; 0x13 -> EXECI; 0x63 -> BEQ; any other opcode -> FETCH.
REQ-013 SHALL sequence MEMADR -> MEMREAD (0x03) or MEMWRITE (0x23), MEMREAD -> MEMWB on MEM_READY, MEMWRITE -> FETCH on MEM_READY, MEMWB -> FETCH, EXECR/EXECI -> ALUWB, ALUWB -> FETCH, and BEQ -> FETCH.
REQ-014 SHALL drive controls in FETCH as: MEM_REQ=1, ADR_SRC=0, ALU_SRC_A=00, ALU_SRC_B=10, ALU_OPE=00, RESULT_SRC=10, with IR_WRITE=1 and PC_WRITE=1 only in the cycle where MEM_READY=1.
REQ-015 SHALL drive controls in the remaining states as:
- DECODE: A=01, B=01, OPE=00.
- MEMADR: A=10, B=01, OPE=00.
- MEMREAD: MEM_REQ=1, ADR_SRC=1, RESULT_SRC=00.
- MEMWB: RESULT_SRC=01, REG_WRITE=1.
- MEMWRITE: MEM_REQ=1, ADR_SRC=1, RESULT_SRC=00, MEM_WRITE=1.
- EXECR: A=10, B=00, OPE=10.
- EXECI: A=10, B=01, OPE=10.
- ALUWB: RESULT_SRC=00, REG_WRITE=1.
- BEQ: A=10, B=00, OPE=01, RESULT_SRC=00, BRANCH=1.
REQ-016 SHALL drive every control not listed for a state to 0.
REQ-017 SHALL compute PC_EN = PC_WRITE | (BRANCH & ZERO) combinationally.
REQ-018 SHALL decode IMM_SRC combinationally from OPE_CODE: 0x23 -> 01; 0x63 -> 10; all other opcodes -> 00.
REQ-019 SHALL count consecutive MEM_READY=0 cycles while MEM_REQ=1, and SHALL clear the count on any state change.
REQ-020 SHALL, when the count reaches WAIT_LIMIT with MEM_READY still 0, pulse MEM_ERR for 1 cycle and go to FETCH on the next edge, with no REG_WRITE or PC_EN issued for the aborted access.
REQ-021 SHALL treat MEM_READY=1 in the limit cycle as normal completion, with no MEM_ERR.
REQ-022 SHALL take 3 cycles for BEQ, 4 for R-type, I-type and sw, and 5 for lw, each with zero wait states.

Reset
REQ-023 SHALL, when RST_N=0 at a clock edge, set state to FETCH, clear the wait count and MEM_ERR, and override any in-flight transition.
REQ-024 SHALL force MEM_REQ, IR_WRITE, MEM_WRITE, REG_WRITE and PC_EN to 0 in any cycle where RST_N=0.
REQ-025 SHALL leave all outputs after release at the FETCH values of REQ-014.

Configuration
REQ-026 SHALL, when macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined, send an unrecognised opcode in DECODE to state TRAP, which holds with all write enables 0 until reset.
REQ-027 SHALL, when the macro is defined, assert output ILLEGAL (1 bit) in TRAP; without the macro, the ILLEGAL port and TRAP state SHALL be absent and unrecognised opcodes return to FETCH.

Structure
REQ-028 SHALL take its state encoding, opcode constants (0x03, 0x13, 0x23, 0x33, 0x63) and 2-bit ALU_OPE/ALU_SRC/RESULT_SRC codes from a shared package, also used by CONTROL_UNIT.
REQ-029 SHALL implement the wait counter and timeout as a sub-module MEM_WAIT_TIMER.

Verification
REQ-030 Bench SHALL check lw (0x03) with MEM_READY always 1: FETCH, DECODE, MEMADR, MEMREAD, MEMWB; REG_WRITE=1 only in MEMWB with RESULT_SRC=01.
REQ-031 Bench SHALL check beq (0x63) with ZERO=1: PC_EN=1 in the BEQ cycle; with ZERO=0: PC_EN=0; both return to FETCH after 3 cycles.
REQ-032 Bench SHALL check sw (0x23) with MEM_READY held 0 for 3 cycles in MEMWRITE: MEM_WRITE=1 held 4 cycles, then FETCH, and MEM_ERR never asserted.
REQ-033 Bench SHALL check WAIT_LIMIT=4 with MEM_READY stuck at 0 in FETCH: MEM_ERR pulses once on the 4th wait cycle, state stays FETCH, and IR_WRITE stays 0.
REQ-034 Bench SHALL check RST_N=0 asserted in EXECR: state is FETCH next edge and REG_WRITE is never asserted.
REQ-035 Bench SHALL check opcode 0x7F: returns to FETCH without the macro; with the macro it enters TRAP, ILLEGAL=1, and the FSM stays in TRAP for 10 cycles.
